// File: rtl/ahb_sram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | ahb_sram_slave: AHB-Lite word-addressed SRAM responder with wait states  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ahb_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int          IDX_W     = $clog2(MEM_DEPTH);
    localparam int          OFF_W     = IDX_W + 2;
    localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * 4);
    localparam logic [3:0]  WAIT_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic             write_q, write_d;
    logic [1:0]       size_q, size_d;

    logic [31:0] mem [MEM_DEPTH];

    logic [31:0]      offset;
    logic             can_accept;
    logic             accept;
    logic             misalign;
    logic             addr_err;
    logic             final_cyc;
    logic             mem_we;
    logic [3:0]       byte_en;
    logic [IDX_W-1:0] word_idx;
    logic             unused_ok;

    assign unused_ok  = HTRANS[0];
    assign offset     = HADDR - BASE_ADDR;
    // ERR2 already shows HREADYOUT=1, so it may take the next address phase.
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign accept     = can_accept && HSEL && HREADY && HTRANS[1];
    assign misalign   = ((HSIZE == 3'd1) && offset[0]) ||
                        ((HSIZE == 3'd2) && (offset[1:0] != 2'b00));
    assign addr_err   = (offset >= MEM_BYTES) || (HSIZE > 3'd2) || misalign;
    assign final_cyc  = (state_q == ST_IDLE) && pend_q;
    assign mem_we     = final_cyc && write_q;
    assign word_idx   = off_q[OFF_W-1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        off_d   = off_q;
        write_d = write_q;
        size_d  = size_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_IDLE;
                    pend_d  = 1'b1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
                if (accept) begin
                    off_d   = offset[OFF_W-1:0];
                    write_d = HWRITE;
                    size_d  = HSIZE[1:0];
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        pend_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            pend_q  <= 1'b0;
            off_q   <= '0;
            write_q <= 1'b0;
            size_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            off_q   <= off_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    // Little-endian lane selection for the committed write.
    always_comb begin
        byte_en = 4'b0000;
        case (size_q)
            2'd0:    byte_en = 4'b0001 << off_q[1:0];
            2'd1:    byte_en = off_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign HREADYOUT = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign HRDATA    = (final_cyc && !write_q) ? mem[word_idx] : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`timescale 1ns/1ps
// Bench for ahb_sram_slave: one instance with one wait state, one with none,
// driven by a pipelined AHB master against a byte-lane memory model.
module tb_ahb_sram_slave;

    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        rstn      [2];
    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [31:0] hwdata    [2];
    logic        hready    [2];
    logic        hreadyout [2];
    logic        hresp     [2];
    logic [31:0] hrdata    [2];

    assign hready[0] = hreadyout[0];
    assign hready[1] = hreadyout[1];

    ahb_sram_slave #(.BASE_ADDR(BASE), .MEM_DEPTH(256), .WAIT_STATES(1)) u_ws1 (
        .HCLK(HCLK), .HRESETn(rstn[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
        .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]),
        .HREADY(hready[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0])
    );

    ahb_sram_slave #(.BASE_ADDR(BASE), .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .HCLK(HCLK), .HRESETn(rstn[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
        .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]),
        .HREADY(hready[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1])
    );

    typedef struct {
        bit          sel;
        logic [1:0]  trans;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic [31:0] model [2][256];
    xfer_t       q[$];
    logic [31:0] rd_log[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    function automatic xfer_t mk(input bit sel, input logic [1:0] trans, input bit wr,
                                 input logic [31:0] addr, input logic [2:0] size,
                                 input logic [31:0] wdata);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata;
        return x;
    endfunction

    function automatic bit is_err(input xfer_t x);
        logic [31:0] off;
        off = x.addr - BASE;
        if (off >= 32'd1024) return 1'b1;
        if (x.size > 3'd2) return 1'b1;
        if (x.size == 3'd1 && off[0]) return 1'b1;
        if (x.size == 3'd2 && off[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input int d, input xfer_t x);
        hsel[d] = x.sel; htrans[d] = x.trans; hwrite[d] = x.wr;
        haddr[d] = x.addr; hsize[d] = x.size;
    endtask

    // Master + scoreboard: issue queued address phases, check each data phase.
    task automatic run_q(input int d);
        xfer_t       dp;
        bit          dp_v = 1'b0;
        bit          dp_acc = 1'b0;
        bit          dp_err = 1'b0;
        int          low = 0;
        int          guard = 0;
        int          exp_low;
        logic [31:0] off;
        logic [31:0] exp_rd;
        int          lane;
        while ((q.size() != 0 || dp_v) && guard < 5000) begin
            @(negedge HCLK);
            guard++;
            hwdata[d] = dp_v ? dp.wdata : 32'h0;
            if (!hreadyout[d]) begin
                low++;
                n_tests++;
                if (hresp[d] !== (dp_v && dp_err)) begin
                    n_fail++;
                    $display("FAIL dut%0d low_hresp addr=%h got %b expected %b", d, dp.addr, hresp[d], dp_v && dp_err);
                end
            end else begin
                if (dp_v) begin
                    off     = dp.addr - BASE;
                    exp_low = !dp_acc ? 0 : (dp_err ? 1 : ws_of(d));
                    exp_rd  = (dp_acc && !dp_err && !dp.wr) ? model[d][off[9:2]] : 32'h0;
                    n_tests++;
                    if (low != exp_low) begin
                        n_fail++;
                        $display("FAIL dut%0d wait_cycles addr=%h got %0d expected %0d", d, dp.addr, low, exp_low);
                    end
                    n_tests++;
                    if (hresp[d] !== dp_err) begin
                        n_fail++;
                        $display("FAIL dut%0d final_hresp addr=%h got %b expected %b", d, dp.addr, hresp[d], dp_err);
                    end
                    n_tests++;
                    if (hrdata[d] !== exp_rd) begin
                        n_fail++;
                        $display("FAIL dut%0d hrdata addr=%h got %h expected %h", d, dp.addr, hrdata[d], exp_rd);
                    end
                    if (dp_acc && !dp_err && !dp.wr) rd_log.push_back(hrdata[d]);
                    if (dp_acc && !dp_err && dp.wr) begin
                        for (int b = 0; b < (1 << dp.size); b++) begin
                            lane = int'(off[1:0]) + b;
                            model[d][off[9:2]][8*lane +: 8] = dp.wdata[8*lane +: 8];
                        end
                    end
                end
                low = 0;
                if (q.size() != 0) begin
                    dp     = q.pop_front();
                    drive(d, dp);
                    dp_v   = 1'b1;
                    dp_acc = dp.sel && dp.trans[1];
                    dp_err = dp_acc && is_err(dp);
                end else begin
                    drive(d, mk(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0));
                    dp_v = 1'b0;
                end
            end
        end
        n_tests++;
        if (guard >= 5000) begin
            n_fail++;
            $display("FAIL dut%0d timeout got %0d cycles expected below 5000", d, guard);
        end
    endtask

    task automatic test_reset;
        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b0;
            drive(d, mk(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0));
            hwdata[d] = 32'h0;
        end
        repeat (3) @(negedge HCLK);
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (hreadyout[d] !== 1'b1) begin n_fail++; $display("FAIL dut%0d reset_hreadyout got %b expected 1", d, hreadyout[d]); end
            n_tests++;
            if (hresp[d] !== 1'b0) begin n_fail++; $display("FAIL dut%0d reset_hresp got %b expected 0", d, hresp[d]); end
            n_tests++;
            if (hrdata[d] !== 32'h0) begin n_fail++; $display("FAIL dut%0d reset_hrdata got %h expected 0", d, hrdata[d]); end
        end
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;
    endtask

    task automatic test_init(input int d);
        for (int i = 0; i < 256; i++)
            q.push_back(mk(1'b1, 2'b10, 1'b1, BASE + 32'(i * 4), 3'd2, $urandom));
        run_q(d);
    endtask

    task automatic test_basic(input int d);
        rd_log.delete();
        q.push_back(mk(1'b1, 2'b10, 1'b1, BASE + 32'h10, 3'd2, 32'hDEAD_BEEF));
        q.push_back(mk(1'b1, 2'b10, 1'b0, BASE + 32'h10, 3'd2, 32'h0));
        run_q(d);
        n_tests++;
        if (rd_log.size() != 1 || rd_log[0] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL dut%0d basic_read got %h expected deadbeef", d, (rd_log.size() != 0) ? rd_log[0] : 32'hx);
        end
    endtask

    task automatic test_lanes(input int d);
        logic [31:0] exp [2];
        exp[0] = 32'hAA22_3344;
        exp[1] = 32'hBEEF_3344;
        rd_log.delete();
        q.push_back(mk(1'b1, 2'b10, 1'b1, BASE + 32'h10, 3'd2, 32'h1122_3344));
        q.push_back(mk(1'b1, 2'b10, 1'b1, BASE + 32'h13, 3'd0, 32'hAAAA_AAAA));
        q.push_back(mk(1'b1, 2'b10, 1'b0, BASE + 32'h10, 3'd2, 32'h0));
        q.push_back(mk(1'b1, 2'b10, 1'b1, BASE + 32'h10, 3'd2, 32'h1122_3344));
        q.push_back(mk(1'b1, 2'b10, 1'b1, BASE + 32'h12, 3'd1, 32'hBEEF_BEEF));
        q.push_back(mk(1'b1, 2'b10, 1'b0, BASE + 32'h10, 3'd2, 32'h0));
        run_q(d);
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (rd_log.size() <= i || rd_log[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL dut%0d lane_read%0d got %h expected %h", d, i, (rd_log.size() > i) ? rd_log[i] : 32'hx, exp[i]);
            end
        end
    endtask

    task automatic test_errors(input int d);
        logic [31:0] w0;
        w0 = model[d][0];
        rd_log.delete();
        q.push_back(mk(1'b1, 2'b10, 1'b0, BASE + 32'h400, 3'd2, 32'h0));
        q.push_back(mk(1'b1, 2'b10, 1'b0, BASE + 32'h002, 3'd2, 32'h0));
        q.push_back(mk(1'b1, 2'b10, 1'b1, BASE + 32'h002, 3'd2, 32'h5555_5555));
        q.push_back(mk(1'b1, 2'b11, 1'b1, BASE + 32'h001, 3'd1, 32'h6666_6666));
        q.push_back(mk(1'b1, 2'b10, 1'b1, BASE + 32'h000, 3'd3, 32'h7777_7777));
        q.push_back(mk(1'b1, 2'b10, 1'b1, BASE - 32'h4,   3'd2, 32'h8888_8888));
        q.push_back(mk(1'b1, 2'b10, 1'b1, BASE + 32'h400, 3'd0, 32'h9999_9999));
        q.push_back(mk(1'b1, 2'b10, 1'b0, BASE + 32'h000, 3'd2, 32'h0));
        q.push_back(mk(1'b1, 2'b10, 1'b1, BASE + 32'h3FF, 3'd0, 32'h5A00_0000));
        q.push_back(mk(1'b1, 2'b10, 1'b0, BASE + 32'h3FC, 3'd2, 32'h0));
        run_q(d);
        n_tests++;
        if (rd_log.size() < 1 || rd_log[0] !== w0) begin
            n_fail++;
            $display("FAIL dut%0d err_no_write got %h expected %h", d, (rd_log.size() > 0) ? rd_log[0] : 32'hx, w0);
        end
        n_tests++;
        if (rd_log.size() < 2 || rd_log[1][31:24] !== 8'h5A) begin
            n_fail++;
            $display("FAIL dut%0d last_byte got %h expected 5a", d, (rd_log.size() > 1) ? rd_log[1][31:24] : 8'hx);
        end
    endtask

    task automatic test_idle(input int d);
        logic [31:0] w5;
        w5 = model[d][5];
        rd_log.delete();
        q.push_back(mk(1'b0, 2'b10, 1'b1, BASE + 32'h14, 3'd2, 32'h1234_5678));
        q.push_back(mk(1'b1, 2'b00, 1'b1, BASE + 32'h14, 3'd2, 32'h2345_6789));
        q.push_back(mk(1'b1, 2'b01, 1'b1, BASE + 32'h14, 3'd2, 32'h3456_789A));
        q.push_back(mk(1'b1, 2'b10, 1'b0, BASE + 32'h14, 3'd2, 32'h0));
        run_q(d);
        n_tests++;
        if (rd_log.size() != 1 || rd_log[0] !== w5) begin
            n_fail++;
            $display("FAIL dut%0d idle_no_write got %h expected %h", d, (rd_log.size() > 0) ? rd_log[0] : 32'hx, w5);
        end
    endtask

    task automatic test_back_to_back(input int d);
        logic [31:0] data [4];
        rd_log.delete();
        for (int i = 0; i < 4; i++) begin
            data[i] = $urandom;
            q.push_back(mk(1'b1, 2'b10, 1'b1, BASE + 32'h40 + 32'(i * 4), 3'd2, data[i]));
        end
        for (int i = 0; i < 4; i++)
            q.push_back(mk(1'b1, (i == 0) ? 2'b10 : 2'b11, 1'b0, BASE + 32'h40 + 32'(i * 4), 3'd2, 32'h0));
        run_q(d);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rd_log.size() <= i || rd_log[i] !== data[i]) begin
                n_fail++;
                $display("FAIL dut%0d b2b_read%0d got %h expected %h", d, i, (rd_log.size() > i) ? rd_log[i] : 32'hx, data[i]);
            end
        end
    endtask

    task automatic test_random(input int d, input int n);
        logic [31:0] a;
        logic [2:0]  sz;
        for (int i = 0; i < n; i++) begin
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a  = BASE + 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 9) != 0) a = a & ~((32'h1 << sz[1:0]) - 32'h1);
            if ($urandom_range(0, 19) == 0) a = a + 32'h400;
            q.push_back(mk($urandom_range(0, 7) != 0, 2'($urandom), 1'($urandom), a, sz, $urandom));
        end
        run_q(d);
    endtask

    task automatic test_reset_midwrite;
        logic [31:0] old;
        logic [31:0] nw;
        old = model[0][8];
        nw  = ~old;
        rd_log.delete();
        @(negedge HCLK);
        drive(0, mk(1'b1, 2'b10, 1'b1, BASE + 32'h20, 3'd2, nw));
        @(negedge HCLK);
        hwdata[0] = nw;
        drive(0, mk(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0));
        n_tests++;
        if (hreadyout[0] !== 1'b0) begin n_fail++; $display("FAIL dut0 midwrite_wait got %b expected 0", hreadyout[0]); end
        #1 rstn[0] = 1'b0;
        #1;
        n_tests++;
        if (hreadyout[0] !== 1'b1) begin n_fail++; $display("FAIL dut0 midrst_hreadyout got %b expected 1", hreadyout[0]); end
        n_tests++;
        if (hresp[0] !== 1'b0) begin n_fail++; $display("FAIL dut0 midrst_hresp got %b expected 0", hresp[0]); end
        n_tests++;
        if (hrdata[0] !== 32'h0) begin n_fail++; $display("FAIL dut0 midrst_hrdata got %h expected 0", hrdata[0]); end
        @(negedge HCLK);
        @(negedge HCLK);
        rstn[0] = 1'b1;
        q.push_back(mk(1'b1, 2'b10, 1'b0, BASE + 32'h20, 3'd2, 32'h0));
        run_q(0);
        n_tests++;
        if (rd_log.size() != 1 || rd_log[0] !== old) begin
            n_fail++;
            $display("FAIL dut0 midrst_old_data got %h expected %h", (rd_log.size() > 0) ? rd_log[0] : 32'hx, old);
        end
    endtask

    initial begin
        test_reset();
        for (int d = 0; d < 2; d++) begin
            test_init(d);
            test_basic(d);
            test_lanes(d);
            test_errors(d);
            test_idle(d);
            test_back_to_back(d);
            test_random(d, 300);
        end
        test_reset_midwrite();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
